// File: rtl/spi_txn_arbiter_if.sv
// Bundle between the SPI transaction arbiter, its requesters and the shared
// SPI master. The slave modport is the arbiter's view.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic                    enable;
  logic [NUM_REQ-1:0]      req;
  logic [3*NUM_REQ-1:0]    req_id;
  logic [8*NUM_REQ-1:0]    req_addr;
  logic [NUM_REQ-1:0]      req_rd;
  logic [16*NUM_REQ-1:0]   req_wdata;
  logic [NUM_REQ-1:0]      req_ack;
  logic [NUM_REQ-1:0]      req_err;
  logic [15:0]             req_rdata;
  logic [IW-1:0]           grant_idx;
  logic                    arb_busy;

  // shared master side
  logic                    start_tx;
  logic [15:0]             cmd_packet;
  logic [15:0]             data_out;
  logic                    spi_busy;
  logic                    tx_done;
  logic [15:0]             data_read;

  modport slave (
    input  enable, req, req_id, req_addr, req_rd, req_wdata,
    input  spi_busy, tx_done, data_read,
    output req_ack, req_err, req_rdata, grant_idx, arb_busy,
    output start_tx, cmd_packet, data_out
  );

  modport master (
    output enable, req, req_id, req_addr, req_rd, req_wdata,
    output spi_busy, tx_done, data_read,
    input  req_ack, req_err, req_rdata, grant_idx, arb_busy,
    input  start_tx, cmd_packet, data_out
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Builds the command packet at grant, launches the master, returns the ack
// and read data, and flags transactions that never complete.
module spi_txn_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  spi_txn_arbiter_if.slave   bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_ERR, S_DRAIN
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic          rd_q;
  logic [CW-1:0] tmo_cnt;

  logic [NUM_REQ-1:0][2:0]  id_a;
  logic [NUM_REQ-1:0][7:0]  addr_a;
  logic [NUM_REQ-1:0][15:0] wdata_a;

  // Unpack the flat per-requester field buses into indexable arrays
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign id_a[g]    = bus.req_id[3*g +: 3];
    assign addr_a[g]  = bus.req_addr[8*g +: 8];
    assign wdata_a[g] = bus.req_wdata[16*g +: 16];
  end

  // First active request searching upward from the one after rr_ptr
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    pick_vld = 1'b0;
    pick     = '0;
    j        = 0;
    jj       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!pick_vld && bus.req[jj]) begin
        pick_vld = 1'b1;
        pick     = jj;
      end
    end
  end

  // Transaction FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= IW'(NUM_REQ - 1);
      rd_q           <= 1'b0;
      tmo_cnt        <= '0;
      bus.req_ack    <= '0;
      bus.req_err    <= '0;
      bus.req_rdata  <= '0;
      bus.grant_idx  <= '0;
      bus.arb_busy   <= 1'b0;
      bus.start_tx   <= 1'b0;
      bus.cmd_packet <= '0;
      bus.data_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Never launch while the master still reports busy
          if (bus.enable && pick_vld && !bus.spi_busy) begin
            bus.grant_idx  <= pick;
            bus.cmd_packet <= {2'b00, id_a[pick], addr_a[pick], 1'b0,
                               bus.req_rd[pick], 1'b0};
            bus.data_out   <= bus.req_rd[pick] ? 16'h0000 : wdata_a[pick];
            rd_q           <= bus.req_rd[pick];
            bus.arb_busy   <= 1'b1;
            bus.start_tx   <= 1'b1;
            state          <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          bus.start_tx <= 1'b0;
          tmo_cnt      <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          // tx_done takes precedence over a coincident timeout
          if (bus.tx_done) begin
            bus.req_ack <= ONE << bus.grant_idx;
            if (rd_q) bus.req_rdata <= bus.data_read;
            state <= S_DONE;
          end else if (tmo_cnt == CW'(TIMEOUT_CYC - 2)) begin
            bus.req_err <= ONE << bus.grant_idx;
            state       <= S_ERR;
          end
        end
        S_DONE: begin
          bus.req_ack  <= '0;
          rr_ptr       <= bus.grant_idx;
          bus.arb_busy <= 1'b0;
          state        <= S_IDLE;
        end
        S_ERR: begin
          bus.req_err <= '0;
          rr_ptr      <= bus.grant_idx;
          state       <= S_DRAIN;
        end
        S_DRAIN: begin
          // A late tx_done here is dropped; wait for the master to go idle
          if (!bus.spi_busy) begin
            bus.arb_busy <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a vector table of single transactions
// followed by hand-written reset, enable, round-robin, busy and timeout cases.
module tb_spi_txn_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  spi_txn_arbiter_if #(.NUM_REQ(NR)) bus();

  spi_txn_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [2:0]  id;
    logic [7:0]  addr;
    logic        rd;
    logic [15:0] wdata;
    logic [15:0] rret;
    logic [15:0] e_cmd;
    logic [15:0] e_dout;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic [2:0] id, input logic [7:0] addr,
                            input logic rd, input logic [15:0] wd);
    bus.req_id[3*i +: 3]     = id;
    bus.req_addr[8*i +: 8]   = addr;
    bus.req_rd[i]            = rd;
    bus.req_wdata[16*i +: 16] = wd;
  endtask

  // Step negedges until start_tx is seen (bounded); lat = negedges taken
  task automatic wait_start(input string nm, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.start_tx && lat < 100);
    if (!bus.start_tx) check({nm, "_start_seen"}, 32'(bus.start_tx), 32'd1);
  endtask

  // Called on the negedge showing start_tx; plays the master and checks the ack
  task automatic finish(input string nm, input int i, input logic [15:0] rret,
                        input logic [15:0] exp_rdata);
    bus.spi_busy = 1'b1;
    @(negedge clk);
    check({nm, "_start_one_cycle"}, 32'(bus.start_tx), 32'd0);
    bus.tx_done   = 1'b1;
    bus.data_read = rret;
    @(negedge clk);
    bus.tx_done   = 1'b0;
    bus.spi_busy  = 1'b0;
    bus.data_read = 16'hDEAD;
    check({nm, "_ack"}, 32'(bus.req_ack), 32'(4'b0001 << i));
    check({nm, "_rdata"}, 32'(bus.req_rdata), 32'(exp_rdata));
    bus.req[i] = 1'b0;
    @(negedge clk);
    check({nm, "_ack_clr"}, 32'(bus.req_ack), 32'd0);
    check({nm, "_busy_clr"}, 32'(bus.arb_busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ack"},   32'(bus.req_ack),    32'd0);
    check({nm, "_err"},   32'(bus.req_err),    32'd0);
    check({nm, "_rdata"}, 32'(bus.req_rdata),  32'd0);
    check({nm, "_grant"}, 32'(bus.grant_idx),  32'd0);
    check({nm, "_abusy"}, 32'(bus.arb_busy),   32'd0);
    check({nm, "_start"}, 32'(bus.start_tx),   32'd0);
    check({nm, "_cmd"},   32'(bus.cmd_packet), 32'd0);
    check({nm, "_dout"},  32'(bus.data_out),   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, starts, abusy, err_at, err_cnt, ack_seen, prev_start;
    int order[5];
    logic [3:0] err_val;

    //       idx id    addr   rd  wdata     rret      cmd       dout      rdata
    vt[0] = '{0, 3'd3, 8'h5A, 0, 16'hBEEF, 16'hF00D, 16'h1AD0, 16'hBEEF, 16'h0000};
    vt[1] = '{2, 3'd1, 8'h10, 1, 16'hFFFF, 16'h1234, 16'h0882, 16'h0000, 16'h1234};
    vt[2] = '{1, 3'd7, 8'hFF, 0, 16'h0001, 16'hF00D, 16'h3FF8, 16'h0001, 16'h1234};
    vt[3] = '{3, 3'd0, 8'h00, 1, 16'h7777, 16'hABCD, 16'h0002, 16'h0000, 16'hABCD};
    vt[4] = '{0, 3'd5, 8'h81, 1, 16'h0000, 16'h5555, 16'h2C0A, 16'h0000, 16'h5555};

    bus.enable = 1'b1; bus.req = '0; bus.req_id = '0; bus.req_addr = '0;
    bus.req_rd = '0; bus.req_wdata = '0; bus.spi_busy = 1'b0;
    bus.tx_done = 1'b0; bus.data_read = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Table: single transactions, master idle at request time
    for (int v = 0; v < 5; v++) begin
      set_fields(vt[v].idx, vt[v].id, vt[v].addr, vt[v].rd, vt[v].wdata);
      bus.req[vt[v].idx] = 1'b1;
      wait_start($sformatf("vec%0d", v), lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd1);
      check($sformatf("vec%0d_grant", v), 32'(bus.grant_idx), 32'(vt[v].idx));
      check($sformatf("vec%0d_cmd", v), 32'(bus.cmd_packet), 32'(vt[v].e_cmd));
      check($sformatf("vec%0d_dout", v), 32'(bus.data_out), 32'(vt[v].e_dout));
      check($sformatf("vec%0d_abusy", v), 32'(bus.arb_busy), 32'd1);
      finish($sformatf("vec%0d", v), vt[v].idx, vt[v].rret, vt[v].e_rdata);
    end

    // Reset in the middle of WAIT, then the next grant waits on spi_busy
    set_fields(2, 3'd2, 8'h22, 1'b0, 16'h2222);
    bus.req[2] = 1'b1;
    wait_start("rstmid", lat);
    bus.spi_busy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rstmid");
    starts = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.start_tx) starts++;
    end
    check("rstmid_no_start_busy", 32'(starts), 32'd0);
    bus.spi_busy = 1'b0;
    @(negedge clk);
    check("rstmid_start_after_busy", 32'(bus.start_tx), 32'd1);
    check("rstmid_cmd", 32'(bus.cmd_packet), 32'h1110);
    finish("rstmid", 2, 16'hF00D, 16'h0000);

    // enable low blocks grants; raising it grants in the next IDLE cycle
    bus.enable = 1'b0;
    set_fields(0, 3'd4, 8'h44, 1'b0, 16'h4444);
    bus.req[0] = 1'b1;
    starts = 0; abusy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.start_tx) starts++;
      if (bus.arb_busy) abusy++;
    end
    check("enable_no_start", 32'(starts), 32'd0);
    check("enable_no_busy", 32'(abusy), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    check("enable_start", 32'(bus.start_tx), 32'd1);
    check("enable_grant", 32'(bus.grant_idx), 32'd0);
    finish("enable", 0, 16'hF00D, 16'h0000);

    // Round-robin with all four requesters continuously requesting
    do_reset();
    for (int i = 0; i < NR; i++) set_fields(i, 3'(i), 8'(i), 1'b0, 16'(i));
    order = '{0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    prev_start = -1;
    for (int n = 0; n < 5; n++) begin
      wait_start($sformatf("rr%0d", n), lat);
      check($sformatf("rr%0d_grant", n), 32'(bus.grant_idx), 32'(order[n]));
      if (prev_start >= 0)
        check($sformatf("rr%0d_gap_ge3", n), 32'(cyc - prev_start >= 3), 32'd1);
      prev_start = cyc;
      finish($sformatf("rr%0d", n), order[n], 16'hF00D, 16'h0000);
      if (n < 4) bus.req[order[n]] = 1'b1;
      else bus.req = '0;
    end

    // spi_busy high holds off the grant
    bus.spi_busy = 1'b1;
    set_fields(1, 3'd6, 8'h66, 1'b1, 16'h6666);
    bus.req[1] = 1'b1;
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.start_tx) starts++;
    end
    check("busygate_no_start", 32'(starts), 32'd0);
    bus.spi_busy = 1'b0;
    @(negedge clk);
    check("busygate_start", 32'(bus.start_tx), 32'd1);
    check("busygate_grant", 32'(bus.grant_idx), 32'd1);
    finish("busygate", 1, 16'h9876, 16'h9876);

    // Timeout: no tx_done in time, late tx_done ignored, drain on spi_busy
    set_fields(0, 3'd2, 8'h33, 1'b0, 16'h3333);
    set_fields(1, 3'd1, 8'h01, 1'b0, 16'h0101);
    bus.req[0] = 1'b1;
    wait_start("tmo", lat);
    bus.spi_busy = 1'b1;
    err_at = 0; err_cnt = 0; ack_seen = 0; starts = 0; err_val = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.req_err != 0) begin
        err_cnt++;
        if (err_at == 0) begin
          err_at  = c;
          err_val = bus.req_err;
          bus.req[0] = 1'b0;
          bus.req[1] = 1'b1;
        end
      end
      if (bus.req_ack != 0) ack_seen++;
      if (bus.start_tx) starts++;
      bus.tx_done = (c == 20);
    end
    bus.tx_done = 1'b0;
    check("tmo_err_cycle", 32'(err_at), 32'd16);
    check("tmo_err_vec", 32'(err_val), 32'h1);
    check("tmo_err_one_cycle", 32'(err_cnt), 32'd1);
    check("tmo_no_ack", 32'(ack_seen), 32'd0);
    check("tmo_no_relaunch", 32'(starts), 32'd0);
    check("tmo_busy_drain", 32'(bus.arb_busy), 32'd1);
    bus.spi_busy = 1'b0;
    @(negedge clk);
    check("tmo_drain_exit", 32'(bus.arb_busy), 32'd0);
    check("tmo_drain_nostart", 32'(bus.start_tx), 32'd0);
    @(negedge clk);
    check("tmo_next_start", 32'(bus.start_tx), 32'd1);
    check("tmo_next_grant", 32'(bus.grant_idx), 32'd1);
    finish("tmo_next", 1, 16'hF00D, 16'h9876);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one spi_master_fsm among NUM_REQ requesters. Each requester presents one read/write transaction (ID, ADDR, READ, write data).
- The block arbitrates round-robin, builds the 16-bit command packet, pulses start_tx and waits for tx_done.
- It returns read data and an ack to the winning requester.
- A watchdog reports hung transactions and keeps the shared master from being re-launched while busy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index width IW = clog2(NUM_REQ), minimum 1.
- TIMEOUT_CYC, 4096, clk cycles allowed from start_tx to tx_done before an error is flagged (>= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new grants; an in-flight transaction completes normally.
- req  in  NUM_REQ  per-requester request level.
- req_id  in  3*NUM_REQ  slave ID, requester i at [3i+2:3i].
- req_addr  in  8*NUM_REQ  register address, requester i at [8i+7:8i].
- req_rd  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  16*NUM_REQ  write data, requester i at [16i+15:16i].
- req_ack  out  NUM_REQ  one-hot one-cycle completion pulse.
- req_err  out  NUM_REQ  one-hot one-cycle timeout pulse.
- req_rdata  out  16  read data, valid in the ack cycle, held until the next ack.
- grant_idx  out  IW  index of the current or last granted requester.
- arb_busy  out  1  high from grant until return to IDLE.
- start_tx  out  1  to master; one-cycle pulse.
- cmd_packet  out  16  to master cmd_packet_in.
- data_out  out  16  to master data_out_in.
- spi_busy  in  1  from master.
- tx_done  in  1  from master; one-cycle pulse.
- data_read  in  16  from master data_read_out.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset values of outputs: req_ack=0, req_err=0, req_rdata=0, grant_idx=0, arb_busy=0, start_tx=0, cmd_packet=0, data_out=0.
- Reset mid-transaction returns to IDLE immediately. The next grant still waits for spi_busy=0.
- All outputs are registered.
- Command format: cmd_packet = {2'b00, id[2:0], addr[7:0], 1'b0 (GLOBAL), rd, 1'b0}.
- For reads, data_out = 16'h0000.
- FSM states:
  - IDLE: if enable & |req & !spi_busy, pick the first set req[i] searching upward from rr_ptr+1 with wrap at NUM_REQ-1 -> 0.
    - Latch grant_idx=i and the fields of requester i into cmd_packet/data_out/rd_q; set arb_busy=1; go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH: start_tx=1 for exactly this cycle; clear the timeout counter; go to WAIT.
    - cmd_packet and data_out are held stable from the grant until the next grant.
  - WAIT: increment the timeout counter every cycle.
    - On tx_done=1: go to DONE.
    - Else, if the counter reaches TIMEOUT_CYC-1: go to ERR.
    - If tx_done and the timeout happen in the same cycle, tx_done wins.
  - DONE (1 cycle): req_ack[grant_idx]=1; if rd_q, req_rdata<=data_read; rr_ptr<=grant_idx.
    - Writes leave req_rdata unchanged.
    - Clear arb_busy; go to IDLE.
  - ERR (1 cycle): req_err[grant_idx]=1; rr_ptr<=grant_idx; go to DRAIN.
  - DRAIN: stay until spi_busy=0, then clear arb_busy and go to IDLE.
    - A late tx_done arriving in DRAIN is ignored; no ack is issued.
- Latency:
  - req seen in IDLE (master idle) at cycle N -> start_tx at N+1.
  - tx_done at cycle M -> req_ack/req_rdata at M+1.
  - Minimum two idle cycles between consecutive start_tx pulses (DONE + IDLE).
- Handshake rules:
  - The requester holds req and its fields until ack/err.
  - Fields are captured at grant, so later changes do not affect the in-flight transaction.
  - req dropped after grant: the transaction still completes and the ack/err is still issued.
  - The requester must deassert req on the clock edge that ends its ack cycle. A req still high in the following IDLE cycle is a new request.
- Fairness: the last-served requester has the lowest priority in the next arbitration. No starvation with up to NUM_REQ continuous requesters.
- enable falling while in WAIT: no effect on the current transaction; blocks the next grant.

Test Plan:
- Single write: req[0]=1, id=3, addr=8'h5A, rd=0, wdata=16'hBEEF -> cmd_packet=16'h1AD0, data_out=16'hBEEF, one start_tx pulse, req_ack[0] one cycle after tx_done, req_rdata unchanged.
- Single read: req[2]=1, id=1, addr=8'h10, rd=1; master model returns 16'h1234 -> cmd_packet=16'h0882, data_out=0, req_ack[2] pulse with req_rdata=16'h1234.
- Round-robin: req=4'b1111 held, each requester re-raising after its ack -> grant order 0,1,2,3,0; exactly one start_tx per grant; >= 2 cycles between start_tx pulses.
- Busy gating: spi_busy forced high while req[1]=1 -> no start_tx until spi_busy falls; start_tx one cycle after grant.
- Timeout: TIMEOUT_CYC=16, master never pulses tx_done and holds spi_busy high 40 cycles -> req_err[grant] pulse 16 cycles after start_tx, no req_ack; late tx_done ignored; next grant only after spi_busy=0.
- Reset mid-WAIT and enable gating: rst=1 for one cycle in WAIT -> all outputs at reset values next cycle; enable=0 with req=4'b0001 -> no grant; raising enable -> grant next IDLE cycle.
